// File: rtl/cardinal_cmp_mem.sv
// Cardinal CMP per-node instruction/data memories plus the run-completion monitor.
// Optional feature: define CMP_CYCLE_COUNTER_EN to build the done/cycle_count monitor.

module cardinal_imem (
  input  logic [0:7]  addr,
  output logic [0:31] data
);

  // Contents arrive only through a preload on the hierarchical path; there is no write port.
  logic [0:31] MEM [0:255];

  assign data = MEM[addr];

endmodule

module cardinal_dmem (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        wr_en,
  input  logic [0:7]  addr,
  input  logic [0:63] d_in,
  output logic [0:63] d_out
);

  logic [0:63] MEM [0:255];

  // The array is not cleared by reset, but a write is suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset && en && wr_en) begin
      MEM[addr] <= d_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out <= '0;
    end else if (en && !wr_en) begin
      d_out <= MEM[addr];
    end
  end

endmodule

module cardinal_cmp_mem (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:31] node0_pc_in,
  output logic [0:31] node0_inst_out,
  input  logic [0:31] node0_addr_in,
  input  logic [0:63] node0_d_in,
  output logic [0:63] node0_d_out,
  input  logic        node0_memEn,
  input  logic        node0_memWrEn,
  input  logic [0:31] node1_pc_in,
  output logic [0:31] node1_inst_out,
  input  logic [0:31] node1_addr_in,
  input  logic [0:63] node1_d_in,
  output logic [0:63] node1_d_out,
  input  logic        node1_memEn,
  input  logic        node1_memWrEn,
  input  logic [0:31] node2_pc_in,
  output logic [0:31] node2_inst_out,
  input  logic [0:31] node2_addr_in,
  input  logic [0:63] node2_d_in,
  output logic [0:63] node2_d_out,
  input  logic        node2_memEn,
  input  logic        node2_memWrEn,
  input  logic [0:31] node3_pc_in,
  output logic [0:31] node3_inst_out,
  input  logic [0:31] node3_addr_in,
  input  logic [0:63] node3_d_in,
  output logic [0:63] node3_d_out,
  input  logic        node3_memEn,
  input  logic        node3_memWrEn,
  output logic        done,
  output logic [0:31] cycle_count
);

  // PC is a byte address; bits [22:29] select the word, so fetches wrap every 1 KB.
  cardinal_imem IM_node0 (.addr(node0_pc_in[22:29]), .data(node0_inst_out));
  cardinal_imem IM_node1 (.addr(node1_pc_in[22:29]), .data(node1_inst_out));
  cardinal_imem IM_node2 (.addr(node2_pc_in[22:29]), .data(node2_inst_out));
  cardinal_imem IM_node3 (.addr(node3_pc_in[22:29]), .data(node3_inst_out));

  cardinal_dmem DM_node0 (
    .clk(clk), .reset(reset), .en(node0_memEn), .wr_en(node0_memWrEn),
    .addr(node0_addr_in[24:31]), .d_in(node0_d_in), .d_out(node0_d_out)
  );
  cardinal_dmem DM_node1 (
    .clk(clk), .reset(reset), .en(node1_memEn), .wr_en(node1_memWrEn),
    .addr(node1_addr_in[24:31]), .d_in(node1_d_in), .d_out(node1_d_out)
  );
  cardinal_dmem DM_node2 (
    .clk(clk), .reset(reset), .en(node2_memEn), .wr_en(node2_memWrEn),
    .addr(node2_addr_in[24:31]), .d_in(node2_d_in), .d_out(node2_d_out)
  );
  cardinal_dmem DM_node3 (
    .clk(clk), .reset(reset), .en(node3_memEn), .wr_en(node3_memWrEn),
    .addr(node3_addr_in[24:31]), .d_in(node3_d_in), .d_out(node3_d_out)
  );

`ifdef CMP_CYCLE_COUNTER_EN
  logic all_nop;

  assign all_nop = (node0_inst_out == 32'h0) && (node1_inst_out == 32'h0) &&
                   (node2_inst_out == 32'h0) && (node3_inst_out == 32'h0);

  // Both outputs freeze once done is set; only reset releases them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done        <= 1'b0;
      cycle_count <= '0;
    end else if (!done) begin
      if (all_nop) begin
        done <= 1'b1;
      end else begin
        cycle_count <= cycle_count + 32'd1;
      end
    end
  end
`else
  assign done        = 1'b0;
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_cardinal_cmp_mem.sv
// Directed self-checking bench for cardinal_cmp_mem; expectations follow CMP_CYCLE_COUNTER_EN.

module tb_cardinal_cmp_mem;

  logic        clk;
  logic        reset;
  logic [0:31] pc       [4];
  logic [0:31] inst     [4];
  logic [0:31] addr     [4];
  logic [0:63] d_in     [4];
  logic [0:63] d_out    [4];
  logic        mem_en   [4];
  logic        mem_wr   [4];
  logic        done;
  logic [0:31] cycle_count;

  int checks = 0;
  int errors = 0;

  cardinal_cmp_mem dut (
    .clk(clk), .reset(reset),
    .node0_pc_in(pc[0]), .node0_inst_out(inst[0]), .node0_addr_in(addr[0]),
    .node0_d_in(d_in[0]), .node0_d_out(d_out[0]), .node0_memEn(mem_en[0]), .node0_memWrEn(mem_wr[0]),
    .node1_pc_in(pc[1]), .node1_inst_out(inst[1]), .node1_addr_in(addr[1]),
    .node1_d_in(d_in[1]), .node1_d_out(d_out[1]), .node1_memEn(mem_en[1]), .node1_memWrEn(mem_wr[1]),
    .node2_pc_in(pc[2]), .node2_inst_out(inst[2]), .node2_addr_in(addr[2]),
    .node2_d_in(d_in[2]), .node2_d_out(d_out[2]), .node2_memEn(mem_en[2]), .node2_memWrEn(mem_wr[2]),
    .node3_pc_in(pc[3]), .node3_inst_out(inst[3]), .node3_addr_in(addr[3]),
    .node3_d_in(d_in[3]), .node3_d_out(d_out[3]), .node3_memEn(mem_en[3]), .node3_memWrEn(mem_wr[3]),
    .done(done), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drive one DMEM request at the negedge, then return just after the sampling posedge.
  task automatic applyStimulus(input int node, input logic en, input logic wr,
                               input logic [0:31] a, input logic [0:63] d);
    @(negedge clk);
    mem_en[node] = en;
    mem_wr[node] = wr;
    addr[node]   = a;
    d_in[node]   = d;
    @(posedge clk);
    #1;
    mem_en[node] = 1'b0;
  endtask

  initial begin
    logic        exp_done;
    logic [31:0] exp_count;

    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      pc[n] = '0; addr[n] = '0; d_in[n] = '0; mem_en[n] = 1'b0; mem_wr[n] = 1'b0;
    end
    // Words 0..9 nonzero, word 10 is NOP, the rest nonzero again.
    for (int i = 0; i < 256; i++) begin
      dut.IM_node0.MEM[i] = (i == 10) ? 32'h0 : 32'hA000_0000 + i;
      dut.IM_node1.MEM[i] = (i == 10) ? 32'h0 : 32'hB100_0000 + i;
      dut.IM_node2.MEM[i] = (i == 10) ? 32'h0 : 32'hC200_0000 + i;
      dut.IM_node3.MEM[i] = (i == 10) ? 32'h0 : 32'hD300_0000 + i;
    end
    dut.IM_node2.MEM[5] = 32'hDEADBEEF;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_d_out0", d_out[0], 64'h0);
    checkOutput("reset_d_out3", d_out[3], 64'h0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_count", cycle_count, 0);

    @(negedge clk);
    reset = 1'b1;

    pc[2] = 32'h14;
    #1;
    checkOutput("imem_node2_pc14", inst[2], 32'hDEADBEEF);
    pc[0] = 32'h0000_0424;
    #1;
    checkOutput("imem_node0_wrap", inst[0], 32'hA000_0009);
    pc[0] = '0;
    pc[2] = '0;

    applyStimulus(1, 1'b1, 1'b1, 32'h7, 64'h0123456789ABCDEF);
    checkOutput("dmem_write_dout_holds", d_out[1], 64'h0);
    checkOutput("dmem_array_written", dut.DM_node1.MEM[7], 64'h0123456789ABCDEF);
    applyStimulus(1, 1'b1, 1'b0, 32'h7, 64'h0);
    checkOutput("dmem_read_back", d_out[1], 64'h0123456789ABCDEF);

    applyStimulus(1, 1'b0, 1'b1, 32'h7, 64'h5555_AAAA_5555_AAAA);
    checkOutput("gated_array", dut.DM_node1.MEM[7], 64'h0123456789ABCDEF);
    checkOutput("gated_dout", d_out[1], 64'h0123456789ABCDEF);

    applyStimulus(1, 1'b1, 1'b1, 32'h8, 64'h1111_2222_3333_4444);
    applyStimulus(1, 1'b1, 1'b0, 32'h8, 64'h0);
    checkOutput("read_addr8", d_out[1], 64'h1111_2222_3333_4444);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0107, 64'h0);
    checkOutput("read_wrap_107", d_out[1], 64'h0123456789ABCDEF);

    applyStimulus(3, 1'b1, 1'b1, 32'h7, 64'hCAFE_F00D_0000_0003);
    checkOutput("node_isolation", dut.DM_node1.MEM[7], 64'h0123456789ABCDEF);

    applyStimulus(0, 1'b1, 1'b1, 32'h3, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(0, 1'b1, 1'b0, 32'h3, 64'h0);
    checkOutput("dout_all_ones", d_out[0], 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef CMP_CYCLE_COUNTER_EN
    checkOutput("count_running", cycle_count != 0, 1);
`endif
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_d_out0", d_out[0], 64'h0);
    checkOutput("async_d_out1", d_out[1], 64'h0);
    checkOutput("async_done", done, 0);
    checkOutput("async_count", cycle_count, 0);

    // Completion run: PCs start at 0 on release and step one word per cycle.
    for (int n = 0; n < 4; n++) pc[n] = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
`ifdef CMP_CYCLE_COUNTER_EN
      exp_done  = (k >= 11);
      exp_count = (k >= 10) ? 32'd10 : k;
`else
      exp_done  = 1'b0;
      exp_count = 32'd0;
`endif
      checkOutput($sformatf("run_done_%0d", k), done, exp_done);
      checkOutput($sformatf("run_count_%0d", k), cycle_count, exp_count);
      @(negedge clk);
      for (int n = 0; n < 4; n++) pc[n] = pc[n] + 32'd4;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
